// File: rtl/jam_cost_table.sv
`default_nettype none
// ============================================================================
//  Module      : jam_cost_table
//  Description : Cost-matrix responder for the job-assignment engine.
//                Holds an 8x8 worker-by-job cost table loaded over a
//                valid/ready stream. It returns Cost one cycle after the
//                engine presents W/J. It captures the engine's final
//                MatchCount/MinCost when Valid is raised, and counts the
//                search cycles spent in READY (saturating).
//  Ports       :
//    CLK, RST                 clock (rising edge), synchronous active-high reset
//    load_valid/load_data     row-major table load stream (W outer, J inner)
//    load_ready               table accepts an entry this cycle
//    load_clear               discard table and restart loading
//    W, J                     worker / job index from the engine
//    Cost                     registered table[{W,J}], 0 until table loaded
//    Valid, MatchCount,
//    MinCost                  engine result strobe and result values
//    tbl_ready                table fully loaded (READY or DONE)
//    res_valid                result captured (DONE)
//    res_match, res_min       captured engine results
//    search_cycles            cycles spent in READY before Valid, saturating
//  Revision    : 1.0  initial release
// ============================================================================
module jam_cost_table #(
  parameter int COST_W = 7,
  parameter int CYC_W  = 20
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load_valid,
  input  logic [COST_W-1:0] load_data,
  output logic              load_ready,
  input  logic              load_clear,
  input  logic [2:0]        W,
  input  logic [2:0]        J,
  output logic [COST_W-1:0] Cost,
  input  logic              Valid,
  input  logic [3:0]        MatchCount,
  input  logic [9:0]        MinCost,
  output logic              tbl_ready,
  output logic              res_valid,
  output logic [3:0]        res_match,
  output logic [9:0]        res_min,
  output logic [CYC_W-1:0]  search_cycles
);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_LOADING = 2'd1,
    S_READY   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [CYC_W-1:0] c_cyc_max = {CYC_W{1'b1}};
  localparam logic [5:0]       c_last    = 6'd63;

  state_t              r_state;
  logic [5:0]          r_ptr;
  logic                r_load_ready;
  logic                r_tbl_ready;
  logic                r_res_valid;
  logic [3:0]          r_res_match;
  logic [9:0]          r_res_min;
  logic [CYC_W-1:0]    r_search_cycles;
  logic [COST_W-1:0]   r_cost;
  logic [COST_W-1:0]   r_table [64];

  logic                w_accept;

  // r_load_ready is high exactly in LOADING, so it doubles as the state
  // qualifier for the handshake. A clear in the same cycle wins.
  assign w_accept = r_load_ready && load_valid && !load_clear;

  // --------------------------------------------------------------------------
  // Control FSM with registered status outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state         <= S_EMPTY;
      r_ptr           <= 6'd0;
      r_load_ready    <= 1'b0;
      r_tbl_ready     <= 1'b0;
      r_res_valid     <= 1'b0;
      r_res_match     <= 4'd0;
      r_res_min       <= 10'd0;
      r_search_cycles <= '0;
    end else if (load_clear) begin
      r_state         <= S_LOADING;
      r_ptr           <= 6'd0;
      r_load_ready    <= 1'b1;
      r_tbl_ready     <= 1'b0;
      r_res_valid     <= 1'b0;
      r_res_match     <= 4'd0;
      r_res_min       <= 10'd0;
      r_search_cycles <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          r_state      <= S_LOADING;
          r_load_ready <= 1'b1;
        end
        S_LOADING: begin
          if (w_accept) begin
            r_ptr <= r_ptr + 6'd1;
            if (r_ptr == c_last) begin
              r_state      <= S_READY;
              r_load_ready <= 1'b0;
              r_tbl_ready  <= 1'b1;
            end
          end
        end
        S_READY: begin
          if (Valid) begin
            // The Valid cycle itself is not counted as a search cycle.
            r_state     <= S_DONE;
            r_res_valid <= 1'b1;
            r_res_match <= MatchCount;
            r_res_min   <= MinCost;
          end else if (r_search_cycles != c_cyc_max) begin
            r_search_cycles <= r_search_cycles + 1'b1;
          end
        end
        S_DONE: begin
          // Results hold; further Valid pulses are ignored.
        end
        default: begin
          r_state      <= S_EMPTY;
          r_load_ready <= 1'b0;
          r_tbl_ready  <= 1'b0;
          r_res_valid  <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Table storage: contents deliberately have no reset so it maps to RAM.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST && w_accept) begin
      r_table[r_ptr] <= load_data;
    end
  end

  // --------------------------------------------------------------------------
  // Read port: one-cycle latency, no enable. Gated by the registered
  // tbl_ready, so the cycle that accepts the 64th write still returns 0.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cost <= '0;
    end else if (r_tbl_ready) begin
      r_cost <= r_table[{W, J}];
    end else begin
      r_cost <= '0;
    end
  end

  assign load_ready    = r_load_ready;
  assign tbl_ready     = r_tbl_ready;
  assign res_valid     = r_res_valid;
  assign res_match     = r_res_match;
  assign res_min       = r_res_min;
  assign search_cycles = r_search_cycles;
  assign Cost          = r_cost;

endmodule
`default_nettype wire

// File: tb/tb_jam_cost_table.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jam_cost_table
//  Description : Self-checking bench for jam_cost_table. A second instance
//                with CYC_W=4 shares all inputs to observe counter saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_jam_cost_table;

  logic       CLK = 1'b0;
  logic       RST;
  logic       load_valid;
  logic [6:0] load_data;
  logic       load_clear;
  logic [2:0] W, J;
  logic       Valid;
  logic [3:0] MatchCount;
  logic [9:0] MinCost;

  logic        load_ready, tbl_ready, res_valid;
  logic [6:0]  Cost;
  logic [3:0]  res_match;
  logic [9:0]  res_min;
  logic [19:0] search_cycles;

  logic        s_load_ready, s_tbl_ready, s_res_valid;
  logic [6:0]  s_Cost;
  logic [3:0]  s_res_match;
  logic [9:0]  s_res_min;
  logic [3:0]  s_search_cycles;

  int n_pass  = 0;
  int n_total = 0;

  logic [6:0] m_table [64];
  logic [6:0] exp_q [$];

  always #5 CLK = ~CLK;

  jam_cost_table #(.COST_W(7), .CYC_W(20)) dut (
    .CLK(CLK), .RST(RST),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .load_clear(load_clear), .W(W), .J(J), .Cost(Cost),
    .Valid(Valid), .MatchCount(MatchCount), .MinCost(MinCost),
    .tbl_ready(tbl_ready), .res_valid(res_valid), .res_match(res_match),
    .res_min(res_min), .search_cycles(search_cycles)
  );

  jam_cost_table #(.COST_W(7), .CYC_W(4)) u_sat (
    .CLK(CLK), .RST(RST),
    .load_valid(load_valid), .load_data(load_data), .load_ready(s_load_ready),
    .load_clear(load_clear), .W(W), .J(J), .Cost(s_Cost),
    .Valid(Valid), .MatchCount(MatchCount), .MinCost(MinCost),
    .tbl_ready(s_tbl_ready), .res_valid(s_res_valid), .res_match(s_res_match),
    .res_min(s_res_min), .search_cycles(s_search_cycles)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Reset held for n edges, released afterwards; DUT is then in EMPTY.
  task automatic do_reset(input int n);
    RST = 1'b1; load_valid = 1'b0; load_data = '0; load_clear = 1'b0;
    W = '0; J = '0; Valid = 1'b0; MatchCount = '0; MinCost = '0;
    repeat (n) tick;
    RST = 1'b0;
  endtask

  // Streams n entries (mode 0: value=index, 1: value 7, 2: random), with
  // optional 1,0,1,0 valid stalls. Bounded; also flags an early tbl_ready.
  task automatic load_all(input int n, input int mode, input bit stall);
    int i = 0;
    int guard = 0;
    bit phase = 1'b1;
    bit early = 1'b0;
    bit acc;
    logic [6:0] d;
    while (i < n && guard < 2000) begin
      if (tbl_ready !== 1'b0) early = 1'b1;
      d = (mode == 0) ? 7'(i) : (mode == 1) ? 7'd7 : 7'($urandom_range(0, 127));
      load_valid = stall ? phase : 1'b1;
      load_data  = d;
      acc = load_valid && (load_ready === 1'b1);
      tick;
      if (acc) begin
        m_table[i] = d;
        i++;
      end
      phase = ~phase;
      guard++;
    end
    load_valid = 1'b0;
    n_total++;
    if (i != n || early)
      $display("FAIL load_stream: accepted %0d early_ready %0d, expected %0d accepted and no early ready", i, early, n);
    else n_pass++;
  endtask

  task automatic test_back_to_back(input int n);
    logic [5:0] idx;
    logic [6:0] e;
    for (int k = 0; k < n; k++) begin
      idx = 6'($urandom_range(0, 63));
      W = idx[5:3]; J = idx[2:0];
      exp_q.push_back(m_table[idx]);
      tick;
      e = exp_q.pop_front();
      n_total++;
      if (Cost !== e) $display("FAIL read_b2b[%0d]: Cost %0d expected %0d", idx, Cost, e);
      else n_pass++;
    end
  endtask

  task automatic test_reset;
    do_reset(2);
    n_total++;
    if ({load_ready, tbl_ready, res_valid} !== 3'b000 || Cost !== 7'd0 ||
        res_match !== 4'd0 || res_min !== 10'd0 || search_cycles !== 20'd0)
      $display("FAIL reset_values: lr %b tr %b rv %b cost %0d rm %0d rmin %0d sc %0d expected all 0",
               load_ready, tbl_ready, res_valid, Cost, res_match, res_min, search_cycles);
    else n_pass++;
    tick;
    n_total++;
    if (load_ready !== 1'b1) $display("FAIL reset_to_loading: load_ready %b expected 1", load_ready);
    else n_pass++;
  endtask

  task automatic test_load_contiguous;
    bit ok_hi = 1'b1;
    bit early = 1'b0;
    logic [6:0] e;
    do_reset(2);
    tick;
    for (int i = 0; i < 64; i++) begin
      if (load_ready !== 1'b1) ok_hi = 1'b0;
      if (tbl_ready !== 1'b0) early = 1'b1;
      load_valid = 1'b1; load_data = 7'(i);
      if (i == 63) begin
        W = 3'd0; J = 3'd5;
        exp_q.push_back(7'd0);
      end
      tick;
      m_table[i] = 7'(i);
    end
    load_valid = 1'b0;
    e = exp_q.pop_front();
    n_total++;
    if (Cost !== e) $display("FAIL cost_on_64th_write: Cost %0d expected %0d", Cost, e);
    else n_pass++;
    n_total++;
    if (!ok_hi || early) $display("FAIL load_ready_64: ok %0d early_ready %0d expected 1 0", ok_hi, early);
    else n_pass++;
    n_total++;
    if (load_ready !== 1'b0 || tbl_ready !== 1'b1)
      $display("FAIL load_complete: load_ready %b tbl_ready %b expected 0 1", load_ready, tbl_ready);
    else n_pass++;
    test_back_to_back(8);
  endtask

  task automatic test_stalls;
    logic [6:0] e;
    do_reset(2);
    tick;
    W = 3'd2; J = 3'd2;
    exp_q.push_back(7'd0);
    tick;
    e = exp_q.pop_front();
    n_total++;
    if (Cost !== e) $display("FAIL read_before_ready: Cost %0d expected %0d", Cost, e);
    else n_pass++;
    load_all(64, 0, 1'b1);
    n_total++;
    if (tbl_ready !== 1'b1) $display("FAIL stall_load_ready: tbl_ready %b expected 1", tbl_ready);
    else n_pass++;
    W = 3'd3; J = 3'd5; exp_q.push_back(7'd29);
    tick;
    e = exp_q.pop_front();
    n_total++;
    if (Cost !== e) $display("FAIL read_3_5: Cost %0d expected %0d", Cost, e);
    else n_pass++;
    W = 3'd7; J = 3'd7; exp_q.push_back(7'd63);
    tick;
    e = exp_q.pop_front();
    n_total++;
    if (Cost !== e) $display("FAIL read_7_7: Cost %0d expected %0d", Cost, e);
    else n_pass++;
    W = 3'd0; J = 3'd0; exp_q.push_back(7'd0);
    tick;
    e = exp_q.pop_front();
    n_total++;
    if (Cost !== e) $display("FAIL read_0_0: Cost %0d expected %0d", Cost, e);
    else n_pass++;
  endtask

  task automatic test_clear_midload;
    do_reset(2);
    tick;
    load_all(30, 0, 1'b0);
    load_clear = 1'b1; load_valid = 1'b1; load_data = 7'd99;
    tick;
    load_clear = 1'b0; load_valid = 1'b0;
    n_total++;
    if (load_ready !== 1'b1 || tbl_ready !== 1'b0)
      $display("FAIL clear_state: load_ready %b tbl_ready %b expected 1 0", load_ready, tbl_ready);
    else n_pass++;
    Valid = 1'b1; MatchCount = 4'd5; MinCost = 10'd77;
    tick;
    Valid = 1'b0;
    n_total++;
    if (res_valid !== 1'b0 || res_match !== 4'd0)
      $display("FAIL valid_in_loading: res_valid %b res_match %0d expected 0 0", res_valid, res_match);
    else n_pass++;
    load_all(64, 1, 1'b0);
    n_total++;
    if (tbl_ready !== 1'b1) $display("FAIL clear_reload_ready: tbl_ready %b expected 1", tbl_ready);
    else n_pass++;
    test_back_to_back(8);
  endtask

  task automatic test_result;
    do_reset(2);
    tick;
    load_all(64, 2, 1'b0);
    repeat (100) tick;
    Valid = 1'b1; MatchCount = 4'd3; MinCost = 10'd240;
    tick;
    Valid = 1'b0;
    n_total++;
    if (res_valid !== 1'b1 || res_match !== 4'd3 || res_min !== 10'd240 || search_cycles !== 20'd100)
      $display("FAIL result_capture: rv %b rm %0d rmin %0d sc %0d expected 1 3 240 100",
               res_valid, res_match, res_min, search_cycles);
    else n_pass++;
    n_total++;
    if (s_search_cycles !== 4'd15) $display("FAIL sat_after_100: sc %0d expected 15", s_search_cycles);
    else n_pass++;
    Valid = 1'b1; MatchCount = 4'd9; MinCost = 10'd5;
    tick;
    Valid = 1'b0;
    tick;
    n_total++;
    if (res_min !== 10'd240 || res_match !== 4'd3 || search_cycles !== 20'd100 || tbl_ready !== 1'b1)
      $display("FAIL result_hold: rm %0d rmin %0d sc %0d tr %b expected 3 240 100 1",
               res_match, res_min, search_cycles, tbl_ready);
    else n_pass++;
    test_back_to_back(8);
  endtask

  task automatic test_reset_done;
    logic [6:0] e;
    RST = 1'b1;
    tick;
    n_total++;
    if ({load_ready, tbl_ready, res_valid} !== 3'b000 || Cost !== 7'd0 ||
        res_match !== 4'd0 || res_min !== 10'd0 || search_cycles !== 20'd0)
      $display("FAIL reset_in_done: lr %b tr %b rv %b cost %0d rm %0d rmin %0d sc %0d expected all 0",
               load_ready, tbl_ready, res_valid, Cost, res_match, res_min, search_cycles);
    else n_pass++;
    RST = 1'b0;
    n_total++;
    if (load_ready !== 1'b0) $display("FAIL empty_after_reset: load_ready %b expected 0", load_ready);
    else n_pass++;
    tick;
    W = 3'd1; J = 3'd1; exp_q.push_back(7'd0);
    tick;
    e = exp_q.pop_front();
    n_total++;
    if (load_ready !== 1'b1 || tbl_ready !== 1'b0 || Cost !== e)
      $display("FAIL reload_required: lr %b tr %b cost %0d expected 1 0 %0d", load_ready, tbl_ready, Cost, e);
    else n_pass++;
  endtask

  task automatic test_saturation;
    do_reset(2);
    tick;
    load_all(64, 2, 1'b0);
    repeat (20) tick;
    n_total++;
    if (s_search_cycles !== 4'd15 || search_cycles !== 20'd20)
      $display("FAIL saturation: sat %0d main %0d expected 15 20", s_search_cycles, search_cycles);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_load_contiguous;
    test_stalls;
    test_clear_midload;
    test_result;
    test_reset_done;
    test_saturation;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/jam_cost_table.md
Name: jam_cost_table

Overview:
- Cost-matrix responder at the far end of the job-assignment engine's W/J/Cost interface.
- Holds the 8x8 worker-by-job cost table, loaded over a valid/ready stream.
- Returns Cost one cycle after the engine presents W/J.
- Captures the engine's final MatchCount/MinCost when the engine raises Valid, and reports search-cycle count; serves as the table model and result collector in system-level runs.

Parameters:
- COST_W, 7, width of one cost entry and of Cost.
- CYC_W, 20, width of the saturating search-cycle counter.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- load_valid  input  1  load stream: load_data is valid.
- load_data  input  COST_W  cost entry, row-major order (W outer, J inner).
- load_ready  output  1  table accepts an entry this cycle.
- load_clear  input  1  discard table and restart loading.
- W  input  3  worker index from the engine.
- J  input  3  job index from the engine.
- Cost  output  COST_W  registered table[W*8+J].
- Valid  input  1  engine result-valid strobe.
- MatchCount  input  4  engine result.
- MinCost  input  10  engine result.
- tbl_ready  output  1  table fully loaded (state READY or DONE).
- res_valid  output  1  result captured (state DONE).
- res_match  output  4  captured MatchCount.
- res_min  output  10  captured MinCost.
- search_cycles  output  CYC_W  cycles spent in READY before Valid, saturating.

Behaviour:
- Clock and reset:
  - One clock, CLK. Reset RST is synchronous and active-high.
  - Reset values: state=EMPTY, write pointer=0, Cost=0, load_ready=0, tbl_ready=0, res_valid=0, res_match=0, res_min=0, search_cycles=0.
  - Table contents are not reset.
- States:
  - EMPTY: load_ready=0. Next state is LOADING (one cycle after reset release).
  - LOADING: load_ready=1. On load_valid&&load_ready, write load_data to table[ptr], ptr+1. When the accepted write has ptr==63, go to READY and drive load_ready=0 in the following cycle. load_valid low leaves ptr unchanged; stalls of any length are allowed.
  - READY: tbl_ready=1. search_cycles+1 per cycle, holding at all-ones. On Valid=1, latch MatchCount->res_match and MinCost->res_min, go to DONE, and set res_valid=1 the next cycle. search_cycles freezes, excluding the Valid cycle itself.
  - DONE: tbl_ready=1 and res_valid=1. Results hold. Later Valid pulses are ignored.
- Read port:
  - Every cycle, Cost <= table[{W,J}] when tbl_ready, else Cost <= 0.
  - Latency is exactly 1 cycle and there is no read enable. The engine changes W/J every cycle and samples Cost the next cycle.
  - In the cycle the 64th write is accepted, the read still returns 0, since tbl_ready is not yet set.
- load_clear:
  - In any state it takes priority over the load handshake and Valid.
  - Next state is LOADING with ptr=0, tbl_ready=0, res_valid=0, search_cycles=0. res_match/res_min are cleared to 0.
- Ignored inputs:
  - Valid outside READY.
  - load_valid outside LOADING.
- Widths: indices are 3-bit. There is no arithmetic on Cost; the sums belong to the engine.
- Reset mid-load or mid-search returns to EMPTY. Reloading is then mandatory (tbl_ready=0 until 64 new writes).

Test Plan:
- Load, contiguous: assert RST 2 cycles, stream 64 entries with table[i]=i (valid every cycle) -> load_ready high 64 cycles then low; tbl_ready=1 the cycle after the 64th accept.
- Load with stalls and read-back: load with load_valid toggling 1,0,1,0…, then drive (W=3,J=5) -> Cost=29 one cycle later. Drive (7,7) then (0,0) back-to-back -> Cost 63 then 0 on consecutive cycles.
- Read before ready: present W=2,J=2 during LOADING -> Cost=0.
- Result capture: load the table, wait 100 cycles in READY, pulse Valid with MatchCount=3, MinCost=10'd240 -> res_valid=1, res_match=3, res_min=240, search_cycles=100. A second Valid with MinCost=5 leaves res_min=240.
- Clear mid-load: clear after 30 writes, then load 64 writes of value 7 -> tbl_ready only after the new 64 writes; any (W,J) returns 7.
- Reset in DONE: assert RST -> all outputs at reset values; load_ready=1 two cycles after release.
- Saturation: force CYC_W=4 and stay in READY 20 cycles -> search_cycles=15.
